wb_shadow_copy_master: RTL and testbench

- Wishbone master that copies a block of 16-bit words from a read-only slave (the BIOS ROM) into a writable slave (shadow RAM) after a start pulse.
- Sits on the same 16-bit, word-addressed (adr[19:1]) Wishbone bus as the ROM slave.
- Drives each word as one read cycle followed by one write cycle.
- Used at boot so the CPU can execute BIOS code from RAM.

---
 rtl/wb_shadow_copy_master.sv | 184 ++++++++++++++++++
 tb/tb_wb_shadow_copy_master.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_shadow_copy_master.sv
// Wishbone master that copies LEN 16-bit words from SRC_BASE to DST_BASE, one read then one write per word.
// Optional ack watchdog with abort: define WB_COPY_TIMEOUT_EN.
module wb_shadow_copy_master #(
  parameter logic [18:0] SRC_BASE = 19'h7FF80,
  parameter logic [18:0] DST_BASE = 19'h07F80,
  parameter int unsigned LEN      = 128,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  input  logic [15:0] wbm_dat_i,
  output logic [15:0] wbm_dat_o,
  output logic [18:0] wbm_adr_o,
  output logic        wbm_we_o,
  output logic        wbm_tga_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  output logic [1:0]  wbm_sel_o,
  input  logic        wbm_ack_i
);

  localparam int unsigned IDX_W = 16;
  localparam int unsigned ADR_W = 19;
  localparam int unsigned DAT_W = 16;
  localparam int unsigned WD_W  = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RGAP, S_WR, S_WGAP, S_DONE} state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic [DAT_W-1:0]  data_q;
  logic [DAT_W-1:0]  dat_o_q;
  logic [ADR_W-1:0]  adr_q;
  logic [ADR_W-1:0]  src_adr_d;
  logic [ADR_W-1:0]  dst_adr_d;
  logic              cyc_q;
  logic              stb_q;
  logic              we_q;
  logic [1:0]        sel_q;
  logic              busy_q;
  logic              done_q;

  // Addresses wrap naturally modulo 2^19.
  assign idx_d     = idx_q + IDX_W'(1);
  assign src_adr_d = SRC_BASE + ADR_W'(idx_q);
  assign dst_adr_d = DST_BASE + ADR_W'(idx_q);

`ifdef WB_COPY_TIMEOUT_EN
  logic [WD_W-1:0] wd_q;
  logic            err_q;
  logic            wd_abort;

  assign wd_abort = ((state_q == S_RD) || (state_q == S_WR)) && !wbm_ack_i
                    && (wd_q == WD_W'(TIMEOUT));
  assign err_o    = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = (WD_W'(TIMEOUT) != '0);
  assign err_o          = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      dat_o_q <= '0;
      adr_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef WB_COPY_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef WB_COPY_TIMEOUT_EN
      err_q  <= 1'b0;
      wd_q   <= '0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_RD;
            busy_q  <= 1'b1;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b0;
            sel_q   <= 2'b11;
            adr_q   <= src_adr_d;
          end
        end
        S_RD: begin
          if (wbm_ack_i) begin
            data_q  <= wbm_dat_i;
            stb_q   <= 1'b0;
            state_q <= S_RGAP;
          end
`ifdef WB_COPY_TIMEOUT_EN
          else begin
            wd_q <= wd_q + WD_W'(1);
          end
`endif
        end
        // Gap cycle swallows the duplicate ack of a registered-ack slave.
        S_RGAP: begin
          state_q <= S_WR;
          stb_q   <= 1'b1;
          we_q    <= 1'b1;
          adr_q   <= dst_adr_d;
          dat_o_q <= data_q;
        end
        S_WR: begin
          if (wbm_ack_i) begin
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q <= S_DONE;
              cyc_q   <= 1'b0;
              sel_q   <= 2'b00;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              idx_q   <= '0;
            end else begin
              idx_q   <= idx_d;
              state_q <= S_WGAP;
            end
          end
`ifdef WB_COPY_TIMEOUT_EN
          else begin
            wd_q <= wd_q + WD_W'(1);
          end
`endif
        end
        S_WGAP: begin
          state_q <= S_RD;
          stb_q   <= 1'b1;
          adr_q   <= src_adr_d;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
`ifdef WB_COPY_TIMEOUT_EN
      // Watchdog expiry overrides whatever the state logic chose this edge.
      if (wd_abort) begin
        state_q <= S_IDLE;
        cyc_q   <= 1'b0;
        stb_q   <= 1'b0;
        we_q    <= 1'b0;
        sel_q   <= 2'b00;
        busy_q  <= 1'b0;
        idx_q   <= '0;
        err_q   <= 1'b1;
      end
`endif
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign wbm_dat_o = dat_o_q;
  assign wbm_adr_o = adr_q;
  assign wbm_we_o  = we_q;
  assign wbm_tga_o = 1'b0;
  assign wbm_stb_o = stb_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_sel_o = sel_q;

endmodule

// File: tb/tb_wb_shadow_copy_master.sv
// Self-checking bench for wb_shadow_copy_master: ROM/RAM slave model with configurable ack latency.
`timescale 1ns/1ps
module tb_wb_shadow_copy_master;

  localparam logic [18:0] SRC = 19'h7FFFE;
  localparam logic [18:0] DST = 19'h07F80;
  localparam int          LEN = 4;
  localparam int          TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, err;
  logic [15:0] dat_i, dat_o;
  logic [18:0] adr;
  logic        we, tga, stb, cyc;
  logic [1:0]  sel;
  logic        ack;

  int   lat    = 1;
  logic no_ack = 1'b0;
  int   wcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_shadow_copy_master #(
    .SRC_BASE(SRC), .DST_BASE(DST), .LEN(LEN), .TIMEOUT(TMO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start),
    .busy_o(busy), .done_o(done), .err_o(err),
    .wbm_dat_i(dat_i), .wbm_dat_o(dat_o), .wbm_adr_o(adr),
    .wbm_we_o(we), .wbm_tga_o(tga), .wbm_stb_o(stb), .wbm_cyc_o(cyc),
    .wbm_sel_o(sel), .wbm_ack_i(ack)
  );

  // ROM word k (counted from SRC) holds 16'h1111*(k+1).
  function automatic logic [15:0] rom(input logic [18:0] a);
    logic [18:0] k;
    k = a - SRC;
    return 16'(16'h1111 * (k[15:0] + 16'd1));
  endfunction

  assign dat_i = rom(adr);

  // Registered ack `lat` cycles after strobe; keeps acking while strobe stays high (duplicate ack).
  always @(posedge clk) begin
    if (rst) begin
      ack  <= 1'b0;
      wcnt <= 0;
    end else begin
      ack  <= cyc & stb & ~no_ack & (wcnt >= lat - 1);
      wcnt <= (cyc & stb) ? wcnt + 1 : 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int lat;
    int burst_len;
    int exp_done;
  } vec_t;

  // Caller enters right after a negedge; that cycle is cycle 0 (start high).
  task automatic run_copy(input int l, input int blen, input int exp_done, input string tag);
    int          done_cyc, done_cnt, busy_bad, bus_bad, burst_bad, burst_n, burst_len, wr_cnt, oob;
    logic        prev_stb, exp_busy, exp_we;
    logic [18:0] badr [8];
    logic        bwe [8];
    logic [15:0] ram [4];
    logic [18:0] off, exp_adr;
    lat = l;
    done_cyc = -1; done_cnt = 0; busy_bad = 0; bus_bad = 0; burst_bad = 0;
    burst_n = 0; burst_len = 0; wr_cnt = 0; oob = 0; prev_stb = 1'b0;
    for (int i = 0; i < 8; i++) begin badr[i] = '0; bwe[i] = 1'b0; end
    for (int i = 0; i < 4; i++) ram[i] = '0;
    start = 1'b1;
    for (int c = 1; c <= exp_done + 3; c++) begin
      @(negedge clk);
      start = (c == exp_done);
      exp_busy = (c < exp_done);
      if (busy !== exp_busy) busy_bad++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (err !== 1'b0) bus_bad++;
      if (cyc !== busy) bus_bad++;
      if (sel !== (cyc ? 2'b11 : 2'b00)) bus_bad++;
      if (tga !== 1'b0) bus_bad++;
      if (stb) begin
        if (!cyc) burst_bad++;
        if (!prev_stb) begin
          if (burst_n < 8) begin badr[burst_n] = adr; bwe[burst_n] = we; end
          burst_n++;
          burst_len = 1;
        end else begin
          burst_len++;
          if (burst_n <= 8 && (adr !== badr[burst_n-1] || we !== bwe[burst_n-1])) burst_bad++;
        end
      end else if (prev_stb && burst_len != blen) begin
        burst_bad++;
      end
      if (cyc && stb && we && ack) begin
        wr_cnt++;
        off = adr - DST;
        if (off < 19'd4) ram[off[1:0]] = dat_o;
        else oob++;
      end
      prev_stb = stb;
    end
    start = 1'b0;
    for (int j = 0; j < 8; j++) begin
      exp_adr = (j % 2 == 0) ? SRC + 19'(j / 2) : DST + 19'(j / 2);
      exp_we  = (j % 2 == 1);
      if (badr[j] !== exp_adr || bwe[j] !== exp_we) burst_bad++;
    end
    chk($sformatf("%s done_cycle", tag), 32'(done_cyc), 32'(exp_done));
    chk($sformatf("%s done_pulses", tag), 32'(done_cnt), 32'd1);
    chk($sformatf("%s busy_mismatch_cycles", tag), 32'(busy_bad), 32'd0);
    chk($sformatf("%s bus_signal_errors", tag), 32'(bus_bad), 32'd0);
    chk($sformatf("%s strobe_bursts", tag), 32'(burst_n), 32'd8);
    chk($sformatf("%s burst_errors", tag), 32'(burst_bad), 32'd0);
    chk($sformatf("%s rd_adr_word2", tag), 32'(badr[4]), 32'h00000);
    chk($sformatf("%s rd_adr_word3", tag), 32'(badr[6]), 32'h00001);
    chk($sformatf("%s ram_writes", tag), 32'(wr_cnt), 32'd4);
    chk($sformatf("%s ram_out_of_range", tag), 32'(oob), 32'd0);
    chk($sformatf("%s ram0", tag), 32'(ram[0]), 32'h1111);
    chk($sformatf("%s ram1", tag), 32'(ram[1]), 32'h2222);
    chk($sformatf("%s ram2", tag), 32'(ram[2]), 32'h3333);
    chk($sformatf("%s ram3", tag), 32'(ram[3]), 32'h4444);
  endtask

  vec_t vecs [3];
  logic found;
`ifdef WB_COPY_TIMEOUT_EN
  int   err_cyc, err_cnt, dcnt;
  logic cyc_at_err, busy_at_err;
`endif

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vecs[0] = '{lat: 1, burst_len: 2, exp_done: 24};
    vecs[1] = '{lat: 3, burst_len: 4, exp_done: 40};
    vecs[2] = '{lat: 2, burst_len: 3, exp_done: 32};

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset cyc", 32'(cyc), 32'd0);
    chk("reset stb", 32'(stb), 32'd0);
    chk("reset we", 32'(we), 32'd0);
    chk("reset sel", 32'(sel), 32'd0);
    chk("reset adr", 32'(adr), 32'd0);
    chk("reset dat_o", 32'(dat_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle cyc", 32'(cyc), 32'd0);

    for (int v = 0; v < 3; v++) begin
      run_copy(vecs[v].lat, vecs[v].burst_len, vecs[v].exp_done, $sformatf("vec%0d", v));
      @(negedge clk);
    end

    // Reset asserted while writing the second word, then a fresh copy.
    lat   = 1;
    found = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 40 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (stb && we && adr == DST + 19'd1) found = 1'b1;
    end
    chk("midreset reached_wr_word1", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset cyc", 32'(cyc), 32'd0);
    chk("midreset stb", 32'(stb), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset we", 32'(we), 32'd0);
    chk("midreset adr", 32'(adr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_copy(1, 2, 24, "after_reset");
    @(negedge clk);

`ifdef WB_COPY_TIMEOUT_EN
    no_ack = 1'b1;
    err_cyc = -1; err_cnt = 0; dcnt = 0; cyc_at_err = 1'b1; busy_at_err = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (err) begin
        err_cnt++;
        if (err_cyc < 0) begin
          err_cyc     = c;
          cyc_at_err  = cyc;
          busy_at_err = busy;
        end
      end
      if (done) dcnt++;
    end
    chk("timeout err_cycle", 32'(err_cyc), 32'd10);
    chk("timeout err_pulses", 32'(err_cnt), 32'd1);
    chk("timeout done_pulses", 32'(dcnt), 32'd0);
    chk("timeout cyc_at_err", 32'(cyc_at_err), 32'd0);
    chk("timeout busy_at_err", 32'(busy_at_err), 32'd0);
    chk("timeout cyc_after", 32'(cyc), 32'd0);
    no_ack = 1'b0;
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
